harvest_sequencer: RTL and testbench

Control-side sequencer for the quad stream grabber. Issues start_harvest requests, tracks the grabber's reporting handshake, and repeats harvests a programmed number of times with a programmable idle gap. Can optionally wait for an external trigger edge before each harvest. Sits on the clk_sys domain, between host control registers and the grabber's start_harvest/reporting pins.

---
 rtl/harvest_seq_pkg.sv | 19 +
 rtl/seq_down_counter.sv | 39 +++
 rtl/harvest_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_harvest_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/harvest_seq_pkg.sv
// harvest_seq_pkg
//   Shared definitions for the harvest sequencer: default parameter widths
//   and the FSM state encoding (IDLE, WAIT_TRIG, START, REPORT, GAP).
//   Build option: HARVEST_SEQ_TIMEOUT_EN (see harvest_sequencer.sv).
package harvest_seq_pkg;

  localparam int HS_CNT_BITS     = 8;
  localparam int HS_GAP_BITS     = 16;
  localparam int HS_TIMEOUT_BITS = 20;

  typedef logic [2:0] hs_state_t;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_TRIG = 3'd1;
  localparam logic [2:0] ST_START     = 3'd2;
  localparam logic [2:0] ST_REPORT    = 3'd3;
  localparam logic [2:0] ST_GAP       = 3'd4;

endpackage

// File: rtl/seq_down_counter.sv
// seq_down_counter
//   Loadable down-counter used for the inter-harvest gap and, when built
//   with HARVEST_SEQ_TIMEOUT_EN, for the watchdog.
// Ports:
//   clk      clock
//   rst      synchronous active-high reset (count -> 0)
//   load     load load_val (has priority over en)
//   load_val value to load
//   en       decrement by one per cycle; holds at zero
//   is_zero  count == 0
//   is_one   count == 1 (last cycle of a loaded interval)
module seq_down_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         is_zero,
  output logic         is_one
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign is_zero = (count == '0);
  assign is_one  = (count == W'(1));

endmodule

// File: rtl/harvest_sequencer.sv
// harvest_sequencer
//   Control-side sequencer for the quad stream grabber. Issues
//   start_harvest, follows the grabber's reporting handshake and repeats
//   harvests num_harvests times (0 = until abort) with gap_cycles idle
//   cycles between the end of one report and the next start. Optionally
//   waits for a trig_in rising edge before each harvest.
//   Build option: define HARVEST_SEQ_TIMEOUT_EN to add a watchdog over
//   START/REPORT that ends the sequence with timeout_err after
//   2**TIMEOUT_BITS-1 cycles; undefined, timeout_err is tied low.
// Ports:
//   clk_sys, srst_sys   clock, synchronous active-high reset
//   arm                 start pulse, accepted only when idle
//   abort               return to idle, highest priority
//   num_harvests        harvests per sequence (0 = run forever)
//   gap_cycles          idle cycles between report end and next start
//   trig_en, trig_in    per-harvest trigger enable / trigger input
//   reporting           grabber reporting flag
//   start_harvest       request to the grabber
//   busy                sequencer not idle
//   done                one-cycle pulse at sequence end (normal or timeout)
//   timeout_err         sticky watchdog flag, cleared by an accepted arm
//   harvest_cnt         completed harvests in the current sequence (wraps)
module harvest_sequencer
  import harvest_seq_pkg::*;
#(
  parameter int CNT_BITS     = HS_CNT_BITS,
  parameter int GAP_BITS     = HS_GAP_BITS,
  parameter int TIMEOUT_BITS = HS_TIMEOUT_BITS
) (
  input  logic                clk_sys,
  input  logic                srst_sys,
  input  logic                arm,
  input  logic                abort,
  input  logic [CNT_BITS-1:0] num_harvests,
  input  logic [GAP_BITS-1:0] gap_cycles,
  input  logic                trig_en,
  input  logic                trig_in,
  input  logic                reporting,
  output logic                start_harvest,
  output logic                busy,
  output logic                done,
  output logic                timeout_err,
  output logic [CNT_BITS-1:0] harvest_cnt
);

  hs_state_t           state;
  hs_state_t           state_next;
  hs_state_t           resume_state;
  logic                trig_d;
  logic                trig_edge;
  logic                gap_load;
  logic                gap_en;
  logic                gap_zero;
  logic                gap_one;
  logic                wd_fire;
  logic                accept_arm;
  logic                inc_cnt;
  logic                seq_end;
  logic                wd_expire;
  logic [CNT_BITS-1:0] cnt_plus1;

  assign trig_edge    = trig_in & ~trig_d;
  assign cnt_plus1    = harvest_cnt + 1'b1;
  // Where a harvest begins: behind the trigger when enabled, else at once.
  assign resume_state = trig_en ? ST_WAIT_TRIG : ST_START;

  // Gap counter: loaded on the REPORT->GAP edge, so the first GAP cycle
  // sees gap_cycles and the last sees 1.
  assign gap_load = (state == ST_REPORT) && (state_next == ST_GAP);
  assign gap_en   = (state == ST_GAP);

  seq_down_counter #(
    .W (GAP_BITS)
  ) u_gap_cnt (
    .clk      (clk_sys),
    .rst      (srst_sys),
    .load     (gap_load),
    .load_val (gap_cycles),
    .en       (gap_en),
    .is_zero  (gap_zero),
    .is_one   (gap_one)
  );

`ifdef HARVEST_SEQ_TIMEOUT_EN
  logic wd_load;
  logic wd_en;
  logic wd_zero;
  logic wd_one;

  // Restarted on every entry to START or REPORT; loaded with the limit so
  // reaching 1 marks the cycle in which the limit is reached.
  assign wd_en   = (state == ST_START) || (state == ST_REPORT);
  assign wd_load = ((state_next == ST_START)  && (state != ST_START)) ||
                   ((state_next == ST_REPORT) && (state != ST_REPORT));

  seq_down_counter #(
    .W (TIMEOUT_BITS)
  ) u_wd_cnt (
    .clk      (clk_sys),
    .rst      (srst_sys),
    .load     (wd_load),
    .load_val ({TIMEOUT_BITS{1'b1}}),
    .en       (wd_en),
    .is_zero  (wd_zero),
    .is_one   (wd_one)
  );

  assign wd_fire = wd_en && (wd_one || wd_zero);

  always_ff @(posedge clk_sys) begin
    if (srst_sys) begin
      timeout_err <= 1'b0;
    end else if (accept_arm) begin
      timeout_err <= 1'b0;
    end else if (wd_expire) begin
      timeout_err <= 1'b1;
    end
  end
`else
  // No watchdog in this build; TIMEOUT_BITS sizes nothing and the term is 0.
  assign wd_fire     = (TIMEOUT_BITS < 0);
  assign timeout_err = 1'b0;
`endif

  // Next-state decode; abort overrides every transition.
  always_comb begin
    state_next = state;
    accept_arm = 1'b0;
    inc_cnt    = 1'b0;
    seq_end    = 1'b0;
    wd_expire  = 1'b0;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arm) begin
            accept_arm = 1'b1;
            state_next = resume_state;
          end
        end
        ST_WAIT_TRIG: begin
          if (trig_edge) begin
            state_next = ST_START;
          end
        end
        ST_START: begin
          if (wd_fire) begin
            wd_expire  = 1'b1;
            state_next = ST_IDLE;
          end else if (reporting) begin
            state_next = ST_REPORT;
          end
        end
        ST_REPORT: begin
          if (wd_fire) begin
            wd_expire  = 1'b1;
            state_next = ST_IDLE;
          end else if (!reporting) begin
            inc_cnt = 1'b1;
            if ((num_harvests != '0) && (cnt_plus1 == num_harvests)) begin
              seq_end    = 1'b1;
              state_next = ST_IDLE;
            end else if (gap_cycles == '0) begin
              state_next = resume_state;
            end else begin
              state_next = ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_one || gap_zero) begin
            state_next = resume_state;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Registered state and outputs; outputs are decoded from the next state.
  always_ff @(posedge clk_sys) begin
    if (srst_sys) begin
      state         <= ST_IDLE;
      trig_d        <= 1'b0;
      start_harvest <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      harvest_cnt   <= '0;
    end else begin
      state         <= state_next;
      trig_d        <= trig_in;
      start_harvest <= (state_next == ST_START);
      busy          <= (state_next != ST_IDLE);
      done          <= seq_end | wd_expire;
      if (accept_arm) begin
        harvest_cnt <= '0;
      end else if (inc_cnt) begin
        harvest_cnt <= cnt_plus1;
      end
    end
  end

endmodule

// File: tb/tb_harvest_sequencer.sv
// tb_harvest_sequencer
//   Randomized and directed bench for harvest_sequencer. A grabber model
//   answers start_harvest with a programmable delay and report length; each
//   sequence is checked against closed-form expectations (done cycle, number
//   of starts, start-high cycles, gap lengths, final count).
//   Build option: HARVEST_SEQ_TIMEOUT_EN selects TIMEOUT_BITS=6 and the
//   watchdog scenario.
module tb_harvest_sequencer;

  localparam int CNT_BITS = 8;
  localparam int GAP_BITS = 16;
`ifdef HARVEST_SEQ_TIMEOUT_EN
  localparam int TO_BITS = 6;
`else
  localparam int TO_BITS = 20;
`endif

  logic                clk_sys = 1'b0;
  logic                srst_sys;
  logic                arm;
  logic                abort;
  logic [CNT_BITS-1:0] num_harvests;
  logic [GAP_BITS-1:0] gap_cycles;
  logic                trig_en;
  logic                trig_in;
  logic                reporting;
  logic                start_harvest;
  logic                busy;
  logic                done;
  logic                timeout_err;
  logic [CNT_BITS-1:0] harvest_cnt;

  always #5 clk_sys = ~clk_sys;

  harvest_sequencer #(
    .CNT_BITS     (CNT_BITS),
    .GAP_BITS     (GAP_BITS),
    .TIMEOUT_BITS (TO_BITS)
  ) dut (
    .clk_sys       (clk_sys),
    .srst_sys      (srst_sys),
    .arm           (arm),
    .abort         (abort),
    .num_harvests  (num_harvests),
    .gap_cycles    (gap_cycles),
    .trig_en       (trig_en),
    .trig_in       (trig_in),
    .reporting     (reporting),
    .start_harvest (start_harvest),
    .busy          (busy),
    .done          (done),
    .timeout_err   (timeout_err),
    .harvest_cnt   (harvest_cnt)
  );

  int n_checks;
  int n_errors;
  int cyc;
  // grabber model
  bit g_on;
  int g_delay;
  int g_len;
  int g_phase;
  int g_cnt;
  // monitor
  int n_rise;
  int n_done;
  int n_fall;
  int n_hi;
  int fall_cyc;
  int done_cyc;
  bit have_fall;
  bit start_prev;
  int gap_q[$];

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic g_reset();
    reporting = 1'b0;
    g_phase   = 0;
    g_cnt     = 0;
    have_fall = 1'b0;
  endtask

  // One clock: outputs observed 1 time unit after the edge, then the grabber
  // model decides what reporting is for the rest of this cycle.
  task automatic step();
    @(posedge clk_sys);
    #1;
    cyc++;
    if (start_harvest === 1'b1) n_hi++;
    if ((start_harvest === 1'b1) && !start_prev) begin
      n_rise++;
      if (have_fall) gap_q.push_back(cyc - fall_cyc);
      have_fall = 1'b0;
    end
    start_prev = (start_harvest === 1'b1);
    if (done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
    end
    if (g_on) begin
      case (g_phase)
        0: if (start_harvest === 1'b1) begin
             g_cnt = 1;
             if (g_delay == 0) begin
               reporting = 1'b1;
               g_phase   = 2;
             end else begin
               g_phase = 1;
             end
           end
        1: if (g_cnt == g_delay) begin
             reporting = 1'b1;
             g_phase   = 2;
             g_cnt     = 1;
           end else begin
             g_cnt++;
           end
        2: if (g_cnt == g_len) begin
             reporting = 1'b0;
             g_phase   = 0;
             n_fall++;
             fall_cyc  = cyc;
             have_fall = 1'b1;
           end else begin
             g_cnt++;
           end
        default: g_phase = 0;
      endcase
    end
  endtask

  task automatic wait_done(input int done0, input int budget);
    int w;
    w = 0;
    while ((n_done == done0) && (w < budget)) begin
      step();
      w++;
    end
    check_val("done_seen", n_done - done0, 1);
  endtask

  // One full sequence without trigger; expectations come from the timing
  // rules: start one cycle after arm, start held d+1 cycles, report l
  // cycles, done one cycle after the last fall, gap g between harvests.
  task automatic run_seq(input int n, input int g, input int d, input int l, input bit noise);
    int rise0, done0, hi0, q0, arm_cyc, exp_done, w;
    num_harvests = CNT_BITS'(n);
    gap_cycles   = GAP_BITS'(g);
    trig_en      = 1'b0;
    g_delay      = d;
    g_len        = l;
    g_reset();
    rise0 = n_rise; done0 = n_done; hi0 = n_hi; q0 = gap_q.size();
    arm     = 1'b1;
    arm_cyc = cyc;
    step();
    arm = 1'b0;
    check_val("arm_latency", int'(start_harvest), 1);
    check_val("arm_cnt_clr", int'(harvest_cnt), 0);
    w = 0;
    while ((n_done == done0) && (w < 3000)) begin
      if (noise && (busy === 1'b1) && ($urandom_range(0, 7) == 0)) arm = 1'b1;
      step();
      arm = 1'b0;
      w++;
    end
    exp_done = arm_cyc + 2 + d + l + (n - 1) * (g + 1 + d + l);
    check_val("done_count", n_done - done0, 1);
    check_val("done_cycle", done_cyc, exp_done);
    check_val("starts", n_rise - rise0, n);
    check_val("start_hi_cycles", n_hi - hi0, n * (d + 1));
    check_val("final_cnt", int'(harvest_cnt), n);
    check_val("busy_end", int'(busy), 0);
    check_val("terr_clean", int'(timeout_err), 0);
    for (int i = q0; i < gap_q.size(); i++) check_val("gap_len", gap_q[i], g + 1);
    step();
    check_val("done_pulse_1cyc", int'(done), 0);
  endtask

  initial begin
    int rise0, done0, fall0, w;
    n_checks = 0; n_errors = 0; cyc = 0;
    n_rise = 0; n_done = 0; n_fall = 0; n_hi = 0;
    fall_cyc = 0; done_cyc = 0; have_fall = 1'b0; start_prev = 1'b0;
    srst_sys = 1'b1; arm = 1'b0; abort = 1'b0; trig_en = 1'b0; trig_in = 1'b0;
    num_harvests = '0; gap_cycles = '0; reporting = 1'b0;
    g_on = 1'b1; g_delay = 3; g_len = 10; g_phase = 0; g_cnt = 0;

    repeat (3) step();
    check_val("rst_start", int'(start_harvest), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_terr", int'(timeout_err), 0);
    check_val("rst_cnt", int'(harvest_cnt), 0);
    srst_sys = 1'b0;
    step();

    run_seq(1, 0, 3, 10, 1'b0);
    run_seq(3, 5, 3, 10, 1'b0);
    run_seq(3, 5, 1, 2, 1'b1);
    for (int k = 0; k < 8; k++) begin
      run_seq($urandom_range(1, 4), $urandom_range(0, 6), $urandom_range(0, 4),
              $urandom_range(1, 5), 1'b1);
      repeat ($urandom_range(0, 3)) step();
    end

    // reporting already high when START is entered: one start cycle only
    g_on = 1'b0; num_harvests = 1; gap_cycles = 0; reporting = 1'b1;
    done0 = n_done;
    arm = 1'b1; step(); arm = 1'b0;
    check_val("prehigh_start", int'(start_harvest), 1);
    step();
    check_val("prehigh_drop", int'(start_harvest), 0);
    check_val("prehigh_busy", int'(busy), 1);
    reporting = 1'b0;
    wait_done(done0, 10);
    check_val("prehigh_cnt", int'(harvest_cnt), 1);
    g_on = 1'b1;

    // trigger held high before arm: no edge until it goes low and rises again
    num_harvests = 1; gap_cycles = 0; trig_en = 1'b1; trig_in = 1'b1;
    g_delay = 2; g_len = 3; g_reset();
    step();
    rise0 = n_rise; done0 = n_done;
    arm = 1'b1; step(); arm = 1'b0;
    check_val("trig_wait_start", int'(start_harvest), 0);
    check_val("trig_wait_busy", int'(busy), 1);
    trig_in = 1'b0;
    repeat (20) step();
    check_val("trig_no_start", n_rise - rise0, 0);
    trig_in = 1'b1;
    step();
    check_val("trig_latency", int'(start_harvest), 1);
    trig_in = 1'b0;
    wait_done(done0, 100);
    check_val("trig_cnt", int'(harvest_cnt), 1);

    // trigger edge during REPORT is discarded, not queued
    num_harvests = 2; gap_cycles = 3; g_delay = 1; g_len = 4; g_reset();
    rise0 = n_rise; done0 = n_done;
    arm = 1'b1; step(); arm = 1'b0;
    trig_in = 1'b1; step(); trig_in = 1'b0;
    w = 0;
    while (!((reporting === 1'b1) && (start_harvest === 1'b0)) && (w < 50)) begin
      step(); w++;
    end
    trig_in = 1'b1; step(); trig_in = 1'b0;
    repeat (30) step();
    check_val("trig_discard_starts", n_rise - rise0, 1);
    check_val("trig_discard_busy", int'(busy), 1);
    check_val("trig_discard_cnt", int'(harvest_cnt), 1);
    trig_in = 1'b1; step(); trig_in = 1'b0;
    wait_done(done0, 100);
    check_val("trig2_starts", n_rise - rise0, 2);
    check_val("trig2_cnt", int'(harvest_cnt), 2);
    trig_en = 1'b0;

    // run forever, abort in the 4th REPORT
    num_harvests = 0; gap_cycles = 2; g_delay = 1; g_len = 3; g_reset();
    rise0 = n_rise; done0 = n_done;
    arm = 1'b1; step(); arm = 1'b0;
    w = 0;
    while (!((n_rise - rise0 == 4) && (reporting === 1'b1) && (start_harvest === 1'b0)) && (w < 500)) begin
      step(); w++;
    end
    abort = 1'b1; step(); abort = 1'b0;
    g_reset();
    check_val("abort_busy", int'(busy), 0);
    check_val("abort_start", int'(start_harvest), 0);
    check_val("abort_cnt", int'(harvest_cnt), 3);
    step();
    check_val("abort_no_done", n_done - done0, 0);
    arm = 1'b1; step(); arm = 1'b0;
    check_val("rearm_cnt", int'(harvest_cnt), 0);
    check_val("rearm_busy", int'(busy), 1);
    abort = 1'b1; step(); abort = 1'b0;
    g_reset();

    // abort together with arm in IDLE stays idle
    arm = 1'b1; abort = 1'b1; step(); arm = 1'b0; abort = 1'b0;
    check_val("abort_arm_busy", int'(busy), 0);
    check_val("abort_arm_start", int'(start_harvest), 0);

    // harvest_cnt wraps in run-forever mode
    num_harvests = 0; gap_cycles = 0; g_delay = 0; g_len = 1; g_reset();
    fall0 = n_fall; done0 = n_done;
    arm = 1'b1; step(); arm = 1'b0;
    w = 0;
    while ((n_fall - fall0 < 256) && (w < 5000)) begin
      step(); w++;
    end
    check_val("pre_wrap_cnt", int'(harvest_cnt), 255);
    step();
    check_val("wrap_cnt", int'(harvest_cnt), 0);
    check_val("wrap_busy", int'(busy), 1);
    check_val("wrap_no_done", n_done - done0, 0);
    abort = 1'b1; step(); abort = 1'b0;
    g_reset();

    // reset during GAP
    num_harvests = 0; gap_cycles = 6; g_delay = 1; g_len = 2; g_reset();
    fall0 = n_fall;
    arm = 1'b1; step(); arm = 1'b0;
    w = 0;
    while (!((n_fall > fall0) && (cyc > fall_cyc)) && (w < 100)) begin
      step(); w++;
    end
    check_val("gap_cnt_before_rst", int'(harvest_cnt), 1);
    srst_sys = 1'b1; step(); srst_sys = 1'b0;
    g_reset();
    check_val("rst_gap_busy", int'(busy), 0);
    check_val("rst_gap_cnt", int'(harvest_cnt), 0);
    check_val("rst_gap_start", int'(start_harvest), 0);

    // reset during START, arm held through the reset cycle
    num_harvests = 1; gap_cycles = 0; g_delay = 20; g_len = 2; g_reset();
    arm = 1'b1; step(); arm = 1'b0;
    check_val("pre_rst_start", int'(start_harvest), 1);
    srst_sys = 1'b1; arm = 1'b1; step();
    check_val("rst_start_drop", int'(start_harvest), 0);
    check_val("rst_start_busy", int'(busy), 0);
    check_val("rst_start_done", int'(done), 0);
    srst_sys = 1'b0; arm = 1'b0; step();
    g_reset();
    check_val("rst_arm_ignored", int'(busy), 0);

`ifdef HARVEST_SEQ_TIMEOUT_EN
    // grabber silent: watchdog ends the sequence after 63 start cycles
    g_on = 1'b0; reporting = 1'b0; num_harvests = 1; gap_cycles = 0;
    begin
      int hi0, arm_cyc;
      hi0 = n_hi; done0 = n_done;
      arm = 1'b1; arm_cyc = cyc; step(); arm = 1'b0;
      w = 0;
      while ((start_harvest === 1'b1) && (w < 200)) begin
        step(); w++;
      end
      check_val("wd_start_cycles", n_hi - hi0, 63);
      check_val("wd_terr", int'(timeout_err), 1);
      check_val("wd_done", n_done - done0, 1);
      check_val("wd_done_cycle", done_cyc, arm_cyc + 64);
      check_val("wd_busy", int'(busy), 0);
      check_val("wd_cnt", int'(harvest_cnt), 0);
      arm = 1'b1; step(); arm = 1'b0;
      check_val("wd_terr_cleared", int'(timeout_err), 0);
      abort = 1'b1; step(); abort = 1'b0;
    end
    g_on = 1'b1;
`else
    // no watchdog: START waits indefinitely for reporting
    g_on = 1'b0; reporting = 1'b0; num_harvests = 1; gap_cycles = 0;
    arm = 1'b1; step(); arm = 1'b0;
    repeat (100) step();
    check_val("nowd_start_held", int'(start_harvest), 1);
    check_val("nowd_terr", int'(timeout_err), 0);
    abort = 1'b1; step(); abort = 1'b0;
    check_val("nowd_abort_start", int'(start_harvest), 0);
    g_on = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
